// File: rtl/pspin_fb_arb_pkg.sv
// Shared configuration for the feedback arbiter: default field widths,
// the packed feedback record, the output-entry state encoding and a
// small round-robin index helper.
package pspin_fb_arb_pkg;

    localparam int unsigned PSPIN_ADDR_WIDTH  = 32;
    localparam int unsigned PSPIN_LEN_WIDTH   = 20;
    localparam int unsigned PSPIN_MSGID_WIDTH = 10;
    localparam int unsigned FB_COUNT_WIDTH    = 32;

    // One feedback record at the default widths.
    typedef struct packed {
        logic [PSPIN_MSGID_WIDTH-1:0] msgid;
        logic [PSPIN_LEN_WIDTH-1:0]   size;
        logic [PSPIN_ADDR_WIDTH-1:0]  addr;
    } pspin_fb_t;

    // Output entry occupancy; FULL is exactly m_valid_o.
    typedef enum logic {
        FB_EMPTY = 1'b0,
        FB_FULL  = 1'b1
    } fb_state_e;

    // Next requester index, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pspin_fb_arb_if.sv
// Feedback bus between the requesters, the arbiter and the packet allocator.
// slave: the arbiter's view. master: the surrounding environment's view.
interface pspin_fb_arb_if
    import pspin_fb_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned ADDR_WIDTH  = PSPIN_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH   = PSPIN_LEN_WIDTH,
    parameter int unsigned MSGID_WIDTH = PSPIN_MSGID_WIDTH
);
    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]             s_valid_i;
    logic [NUM_PORTS-1:0]             s_ready_o;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_addr_i;
    logic [NUM_PORTS*LEN_WIDTH-1:0]   s_size_i;
    logic [NUM_PORTS*MSGID_WIDTH-1:0] s_msgid_i;

    logic                   m_valid_o;
    logic                   m_ready_i;
    logic [ADDR_WIDTH-1:0]  m_addr_o;
    logic [LEN_WIDTH-1:0]   m_size_o;
    logic [MSGID_WIDTH-1:0] m_msgid_o;
    logic [IDX_W-1:0]       m_src_o;

    modport slave (
        input  s_valid_i, s_addr_i, s_size_i, s_msgid_i, m_ready_i,
        output s_ready_o, m_valid_o, m_addr_o, m_size_o, m_msgid_o, m_src_o
    );

    modport master (
        output s_valid_i, s_addr_i, s_size_i, s_msgid_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_addr_o, m_size_o, m_msgid_o, m_src_o
    );

endinterface

// File: rtl/pspin_fb_arb_rr_pick.sv
// Rotating-priority pick: first asserted request strictly after 'last',
// wrapping around, so the most recent winner has lowest priority.
module pspin_rr_pick
    import pspin_fb_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_vld
);

    int unsigned pos;

    // Walk the ring once starting after 'last'; keep the first hit.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        pos     = int'(last);
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            pos = rr_next(pos, NUM_PORTS);
            if (!gnt_vld && req[pos]) begin
                gnt_idx = IDX_W'(pos);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pspin_fb_arb.sv
// Merges per-requester HER feedback into a single registered stream towards
// the packet allocator. Round-robin fair, one accept per cycle, fields are
// passed through untouched (size classification is the allocator's job).
module pspin_fb_arb
    import pspin_fb_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned ADDR_WIDTH  = PSPIN_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH   = PSPIN_LEN_WIDTH,
    parameter int unsigned MSGID_WIDTH = PSPIN_MSGID_WIDTH,
    // Counter value loaded by reset; nonzero only for bring-up/wrap checks.
    parameter logic [FB_COUNT_WIDTH-1:0] FB_COUNT_INIT = '0
) (
    input  logic                      clk,
    input  logic                      rstn,
    pspin_fb_arb_if.slave             bus,
    output logic [FB_COUNT_WIDTH-1:0] fb_count_o
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    fb_state_e              state_reg, state_next;
    logic [IDX_W-1:0]       last_reg;
    logic [IDX_W-1:0]       src_reg;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [LEN_WIDTH-1:0]   size_reg;
    logic [MSGID_WIDTH-1:0] msgid_reg;
    logic [FB_COUNT_WIDTH-1:0] fb_count_reg;

    logic             load_en;
    logic             grant;
    logic             xfer;
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_PORTS];
    logic [LEN_WIDTH-1:0]   size_arr  [NUM_PORTS];
    logic [MSGID_WIDTH-1:0] msgid_arr [NUM_PORTS];

    // Unpack the flat requester buses and drive the one-hot accept.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign addr_arr[gi]      = bus.s_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign size_arr[gi]      = bus.s_size_i[gi*LEN_WIDTH +: LEN_WIDTH];
        assign msgid_arr[gi]     = bus.s_msgid_i[gi*MSGID_WIDTH +: MSGID_WIDTH];
        assign bus.s_ready_o[gi] = grant && (gnt_idx == IDX_W'(gi));
    end

    pspin_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req     (bus.s_valid_i),
        .last    (last_reg),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // The entry may be refilled when empty or when it drains this cycle;
    // nothing is accepted while reset is held.
    assign xfer    = (state_reg == FB_FULL) && bus.m_ready_i;
    assign load_en = (state_reg == FB_EMPTY) || bus.m_ready_i;
    assign grant   = rstn && load_en && gnt_vld;

    // Occupancy register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= FB_EMPTY;
        else       state_reg <= state_next;
    end

    // Next occupancy: a grant always fills, a drain without refill empties.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FB_EMPTY: if (grant) state_next = FB_FULL;
            FB_FULL:  if (!grant && bus.m_ready_i) state_next = FB_EMPTY;
            default:  state_next = FB_EMPTY;
        endcase
    end

    // Capture the winner's fields; hold them otherwise so the output is
    // stable under backpressure. last_reg starts at the top port so port 0
    // wins first after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_reg  <= '0;
            size_reg  <= '0;
            msgid_reg <= '0;
            src_reg   <= '0;
            last_reg  <= IDX_W'(NUM_PORTS - 1);
        end else if (grant) begin
            addr_reg  <= addr_arr[gnt_idx];
            size_reg  <= size_arr[gnt_idx];
            msgid_reg <= msgid_arr[gnt_idx];
            src_reg   <= gnt_idx;
            last_reg  <= gnt_idx;
        end
    end

    // Count delivered feedbacks; wraps naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     fb_count_reg <= FB_COUNT_INIT;
        else if (xfer) fb_count_reg <= fb_count_reg + FB_COUNT_WIDTH'(1);
    end

    assign bus.m_valid_o = (state_reg == FB_FULL);
    assign bus.m_addr_o  = addr_reg;
    assign bus.m_size_o  = size_reg;
    assign bus.m_msgid_o = msgid_reg;
    assign bus.m_src_o   = src_reg;
    assign fb_count_o    = fb_count_reg;

endmodule

// File: tb/tb_pspin_fb_arb.sv
// Directed bench for pspin_fb_arb: single grant latency, round-robin
// sequence, backpressure hold, async reset while full, counter wrap and
// zero-size passthrough.
module tb_pspin_fb_arb;
    import pspin_fb_arb_pkg::*;

    localparam int NP = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [31:0] fb_count;
    logic [31:0] fb_count_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pspin_fb_arb_if #(.NUM_PORTS(NP)) bus ();
    pspin_fb_arb_if #(.NUM_PORTS(NP)) bus_w ();

    pspin_fb_arb #(.NUM_PORTS(NP)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .fb_count_o (fb_count)
    );

    // Second instance whose counter resets to all-ones, for the wrap check.
    pspin_fb_arb #(.NUM_PORTS(NP), .FB_COUNT_INIT(32'hFFFF_FFFF)) dut_w (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus_w),
        .fb_count_o (fb_count_w)
    );

    // One line per delivered feedback.
    always @(posedge clk) begin
        if (rstn && bus.m_valid_o && bus.m_ready_i)
            $display("xfer dut   src=%0d addr=%h size=%0d msgid=%0d", bus.m_src_o, bus.m_addr_o, bus.m_size_o, bus.m_msgid_o);
        if (rstn && bus_w.m_valid_o && bus_w.m_ready_i)
            $display("xfer dut_w src=%0d addr=%h size=%0d msgid=%0d", bus_w.m_src_o, bus_w.m_addr_o, bus_w.m_size_o, bus_w.m_msgid_o);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int i, input logic v, input pspin_fb_t f);
        bus.s_valid_i[i]           = v;
        bus.s_addr_i[i*32 +: 32]   = f.addr;
        bus.s_size_i[i*20 +: 20]   = f.size;
        bus.s_msgid_i[i*10 +: 10]  = f.msgid;
    endtask

    function automatic pspin_fb_t rr_vec(input int i);
        pspin_fb_t f;
        f.addr  = 32'h1000_0000 + 32'(i) * 32'h100;
        f.size  = 20'(64 * (i + 1));
        f.msgid = 10'(i + 1);
        return f;
    endfunction

    initial begin
        pspin_fb_t f;
        bus.s_valid_i = '0;   bus.s_addr_i = '0;   bus.s_size_i = '0;
        bus.s_msgid_i = '0;   bus.m_ready_i = 1'b0;
        bus_w.s_valid_i = '0; bus_w.s_addr_i = '0; bus_w.s_size_i = '0;
        bus_w.s_msgid_i = '0; bus_w.m_ready_i = 1'b0;

        // Reset state, with requests present that must not be accepted.
        rstn = 1'b0;
        bus.s_valid_i = '1;
        bus.m_ready_i = 1'b1;
        #2;
        check("rst_s_ready", 64'(bus.s_ready_o), 64'h0);
        check("rst_m_valid", 64'(bus.m_valid_o), 64'h0);
        check("rst_count",   64'(fb_count), 64'h0);
        check("rst_addr",    64'(bus.m_addr_o), 64'h0);
        check("rst_src",     64'(bus.m_src_o), 64'h0);
        bus.s_valid_i = '0;
        @(negedge clk);
        rstn = 1'b1;

        // Single request on port 2.
        @(negedge clk);
        f = '{msgid: 10'd5, size: 20'd1536, addr: 32'h1c10_0600};
        set_port(2, 1'b1, f);
        #1 check("t1_s_ready", 64'(bus.s_ready_o), 64'b0100);
        @(posedge clk); #1;
        bus.s_valid_i = '0;
        check("t1_m_valid", 64'(bus.m_valid_o), 64'h1);
        check("t1_addr",    64'(bus.m_addr_o), 64'h1c10_0600);
        check("t1_size",    64'(bus.m_size_o), 64'd1536);
        check("t1_msgid",   64'(bus.m_msgid_o), 64'd5);
        check("t1_src",     64'(bus.m_src_o), 64'd2);
        check("t1_count0",  64'(fb_count), 64'd0);
        @(posedge clk); #1;
        check("t1_count1",  64'(fb_count), 64'd1);
        check("t1_empty",   64'(bus.m_valid_o), 64'h0);

        // Fresh reset, then all four ports valid continuously.
        rstn = 1'b0; #1 rstn = 1'b1;
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, rr_vec(i));
        for (int c = 0; c < 8; c++) begin
            #1 check("t2_s_ready", 64'(bus.s_ready_o), 64'(1) << (c % 4));
            @(posedge clk); #1;
            f = rr_vec(c % 4);
            check("t2_src",   64'(bus.m_src_o), 64'(c % 4));
            check("t2_addr",  64'(bus.m_addr_o), 64'(f.addr));
            check("t2_count", 64'(fb_count), 64'(c));
        end
        bus.s_valid_i = '0;
        @(posedge clk); #1;
        check("t2_count8", 64'(fb_count), 64'd8);
        check("t2_empty",  64'(bus.m_valid_o), 64'h0);

        // Backpressure with ports 1 and 3 requesting.
        bus.m_ready_i = 1'b0;
        set_port(1, 1'b1, '{msgid: 10'd11, size: 20'd100, addr: 32'h2000_0100});
        set_port(3, 1'b1, '{msgid: 10'd33, size: 20'd300, addr: 32'h2000_0300});
        #1 check("t3_s_ready0", 64'(bus.s_ready_o), 64'b0010);
        @(posedge clk); #1;
        for (int h = 0; h < 5; h++) begin
            check("t3_hold_ready", 64'(bus.s_ready_o), 64'h0);
            check("t3_hold_valid", 64'(bus.m_valid_o), 64'h1);
            check("t3_hold_src",   64'(bus.m_src_o), 64'd1);
            check("t3_hold_addr",  64'(bus.m_addr_o), 64'h2000_0100);
            check("t3_hold_msgid", 64'(bus.m_msgid_o), 64'd11);
            @(posedge clk); #1;
        end
        check("t3_hold_count", 64'(fb_count), 64'd8);
        bus.m_ready_i = 1'b1;
        #1 check("t3_s_ready1", 64'(bus.s_ready_o), 64'b1000);
        @(posedge clk); #1;
        check("t3_src",   64'(bus.m_src_o), 64'd3);
        check("t3_addr",  64'(bus.m_addr_o), 64'h2000_0300);
        check("t3_count", 64'(fb_count), 64'd9);
        bus.s_valid_i = '0;
        @(posedge clk); #1;
        check("t3_count_end", 64'(fb_count), 64'd10);
        check("t3_empty",     64'(bus.m_valid_o), 64'h0);

        // Asynchronous reset while FULL.
        bus.m_ready_i = 1'b0;
        set_port(1, 1'b1, '{msgid: 10'd21, size: 20'd210, addr: 32'h3000_0100});
        set_port(2, 1'b1, '{msgid: 10'd22, size: 20'd220, addr: 32'h3000_0200});
        @(posedge clk); #1;
        check("t4_full_src", 64'(bus.m_src_o), 64'd1);
        rstn = 1'b0;
        #1;
        check("t4_rst_valid", 64'(bus.m_valid_o), 64'h0);
        check("t4_rst_count", 64'(fb_count), 64'h0);
        check("t4_rst_addr",  64'(bus.m_addr_o), 64'h0);
        check("t4_rst_src",   64'(bus.m_src_o), 64'h0);
        check("t4_rst_ready", 64'(bus.s_ready_o), 64'h0);
        #1 rstn = 1'b1;
        bus.m_ready_i = 1'b1;
        #1 check("t4_s_ready", 64'(bus.s_ready_o), 64'b0010);
        @(posedge clk); #1;
        check("t4_src",   64'(bus.m_src_o), 64'd1);
        check("t4_addr",  64'(bus.m_addr_o), 64'h3000_0100);
        bus.s_valid_i = '0;
        @(posedge clk); #1;
        check("t4_count", 64'(fb_count), 64'd1);

        // Counter wrap and zero-size passthrough on the preloaded instance.
        check("t5_count_pre", 64'(fb_count_w), 64'hFFFF_FFFF);
        bus_w.s_valid_i[0]  = 1'b1;
        bus_w.s_addr_i[31:0] = 32'hdead_0000;
        bus_w.s_size_i[19:0] = 20'd0;
        bus_w.s_msgid_i[9:0] = 10'h3ff;
        bus_w.m_ready_i = 1'b1;
        #1 check("t5_s_ready", 64'(bus_w.s_ready_o), 64'b0001);
        @(posedge clk); #1;
        bus_w.s_valid_i = '0;
        check("t5_m_valid", 64'(bus_w.m_valid_o), 64'h1);
        check("t5_size",    64'(bus_w.m_size_o), 64'h0);
        check("t5_msgid",   64'(bus_w.m_msgid_o), 64'h3ff);
        check("t5_addr",    64'(bus_w.m_addr_o), 64'hdead_0000);
        @(posedge clk); #1;
        check("t5_count_wrap", 64'(fb_count_w), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
